dm_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the word-organised data memory. It arbitrates between requester 0 (CPU load/store stage) and requester 1 (debug/loader port), and latches the winning command. It drives the memory's `dm_w`/`dm_r`/`dm_op`/address/write-data inputs for exactly one cycle, captures the read word, and returns it with a completion pulse. Sits between the MEM stage and the data memory, and is the only driver of the memory's control inputs.

---
 rtl/dm_arbiter.sv | 129 ++++++++++++
 tb/tb_dm_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and single-access sequencer for the word-organised data memory.
// One latched command at a time: IDLE -> ACCESS (strobes, ack) -> RESP (done) -> IDLE.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access in flight; picks a winner when any request is high
// ACCESS | latched command driven to memory for one cycle; ack pulses
// RESP   | read word captured; done pulses to the latched requester
module dm_arbiter #(
   parameter logic PRIO_INIT = 1'b0,
   parameter int   ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [2:0]        op0,
   input  logic [2:0]        op1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              done0,
   output logic              done1,
   output logic [31:0]       rdata0,
   output logic [31:0]       rdata1,
   output logic              busy,
   output logic              dm_w,
   output logic              dm_r,
   output logic [2:0]        dm_op,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wdata,
   input  logic [31:0]       dm_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              last_q;
   logic              id_q;
   logic              we_q;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata0_q, rdata1_q;
   logic              any_req;
   logic              grant_id;
   logic              accept;

   // Under contention the requester that did not win last time goes first.
   assign any_req  = req0 | req1;
   assign grant_id = (req0 && req1) ? ~last_q : req1;
   assign accept   = (state_q == IDLE) && any_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= ~PRIO_INIT;
         id_q     <= 1'b0;
         we_q     <= 1'b0;
         op_q     <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_q  <= grant_id;
            id_q    <= grant_id;
            we_q    <= grant_id ? we1    : we0;
            op_q    <= grant_id ? op1    : op0;
            addr_q  <= grant_id ? addr1  : addr0;
            wdata_q <= grant_id ? wdata1 : wdata0;
         end
         // Memory read data settles by the falling edge of ACCESS; capture it at the end of ACCESS.
         if ((state_q == ACCESS) && !we_q) begin
            if (id_q) rdata1_q <= dm_rdata;
            else      rdata0_q <= dm_rdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ack0    = 1'b0;
      ack1    = 1'b0;
      done0   = 1'b0;
      done1   = 1'b0;
      dm_w    = 1'b0;
      dm_r    = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) state_d = ACCESS;
         end
         ACCESS: begin
            state_d = RESP;
            dm_w    = we_q;
            dm_r    = ~we_q;
            ack0    = ~id_q;
            ack1    = id_q;
         end
         RESP: begin
            state_d = IDLE;
            done0   = ~id_q;
            done1   = id_q;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign dm_op    = op_q;
   assign dm_addr  = addr_q;
   assign dm_wdata = wdata_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed stimulus pushes expected ack/done records,
// a falling-edge monitor pops and compares them against the DUT and a small memory model.
module tb_dm_arbiter;

   localparam logic [2:0] DM_OP_SB = 3'd1;
   localparam logic [2:0] DM_OP_W  = 3'd3;
   localparam logic [2:0] DM_OP_BZ = 3'd5;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [2:0]  op0, op1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, done0, done1, busy, dm_w, dm_r;
   logic [31:0] rdata0, rdata1;
   logic [2:0]  dm_op;
   logic [31:0] dm_addr, dm_wdata;
   logic [31:0] dm_rdata = 32'h0;

   always #5 clk = ~clk;

   dm_arbiter #(.PRIO_INIT(1'b0), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .op0(op0), .op1(op1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .dm_w(dm_w), .dm_r(dm_r), .dm_op(dm_op), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
   );

   // Word memory model: byte store / zero-extended byte load on lane addr[1:0].
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (dm_w) begin
         if (dm_op == DM_OP_SB) mem[dm_addr[7:2]][{dm_addr[1:0], 3'b000} +: 8] = dm_wdata[7:0];
         else                   mem[dm_addr[7:2]] = dm_wdata;
      end
   end
   always @(negedge clk) begin
      if (dm_r) begin
         if (dm_op == DM_OP_BZ) dm_rdata = {24'h0, mem[dm_addr[7:2]][{dm_addr[1:0], 3'b000} +: 8]};
         else                   dm_rdata = mem[dm_addr[7:2]];
      end else begin
         dm_rdata = 32'h0;
      end
   end

   typedef struct {
      logic        id;
      logic        we;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          cyc;
   } ack_t;

   typedef struct {
      logic        id;
      logic        ld;
      logic [31:0] rdata;
      int          cyc;
   } done_t;

   ack_t        ack_q[$];
   done_t       done_q[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   bit          mon_en = 1'b0;
   logic [31:0] sh0 = 32'h0;
   logic [31:0] sh1 = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (ack0 || ack1) begin
            chk("ack_expected", 32'(ack_q.size() != 0), 32'd1);
            if (ack_q.size() != 0) begin
               ack_t a;
               a = ack_q.pop_front();
               chk("ack_cycle", 32'(cyc), 32'(a.cyc));
               chk("ack_id", {30'h0, ack1, ack0}, a.id ? 32'd2 : 32'd1);
               chk("strobes", {30'h0, dm_w, dm_r}, a.we ? 32'd2 : 32'd1);
               chk("dm_addr", dm_addr, a.addr);
               chk("dm_op", 32'(dm_op), 32'(a.op));
               chk("dm_wdata", dm_wdata, a.wdata);
               chk("busy_access", 32'(busy), 32'd1);
            end
         end else begin
            chk("idle_strobes", {30'h0, dm_w, dm_r}, 32'd0);
         end
         if (done0 || done1) begin
            chk("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
               done_t d;
               d = done_q.pop_front();
               chk("done_cycle", 32'(cyc), 32'(d.cyc));
               chk("done_id", {30'h0, done1, done0}, d.id ? 32'd2 : 32'd1);
               chk("busy_resp", 32'(busy), 32'd1);
               if (d.ld) begin
                  if (d.id) sh1 = d.rdata;
                  else      sh0 = d.rdata;
               end
               chk("rdata0", rdata0, sh0);
               chk("rdata1", rdata1, sh1);
            end
         end
      end
   end

   task automatic set_port(input logic id, input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wd);
      if (id) begin we1 = we; op1 = op; addr1 = addr; wdata1 = wd; end
      else    begin we0 = we; op0 = op; addr0 = addr; wdata0 = wd; end
   endtask

   // Entered just after a rising edge; returns just after the edge that starts the IDLE cycle.
   task automatic single(input logic id, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp);
      int k;
      k = cyc;
      set_port(id, we, op, addr, wd);
      if (id) req1 = 1'b1; else req0 = 1'b1;
      ack_q.push_back('{id, we, op, addr, wd, k + 1});
      done_q.push_back('{id, ~we, exp, k + 2});
      @(posedge clk); #1;
      @(posedge clk); #1;
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int k;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0]  = 32'hA0A0A0A0;
      mem[1]  = 32'hB1B1B1B1;
      mem[2]  = 32'hC2C2C2C2;
      mem[4]  = 32'hDEADBEEF;
      mem[12] = 32'h11223344;
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      set_port(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      set_port(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", {30'h0, ack1, ack0}, 32'd0);
      chk("rst_done", {30'h0, done1, done0}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", {30'h0, dm_w, dm_r}, 32'd0);
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_dm_addr", dm_addr, 32'h0);
      chk("rst_dm_wdata", dm_wdata, 32'h0);
      chk("rst_dm_op", 32'(dm_op), 32'd0);
      mon_en = 1'b1;

      // Contention straight out of reset: 0 wins first, then strict alternation.
      @(posedge clk); #1;
      k = cyc;
      rst = 1'b0;
      set_port(1'b0, 1'b0, DM_OP_W, 32'h10, 32'h0);
      set_port(1'b1, 1'b0, DM_OP_W, 32'h04, 32'h0);
      req0 = 1'b1; req1 = 1'b1;
      ack_q.push_back('{1'b0, 1'b0, DM_OP_W, 32'h10, 32'h0, k + 1});
      ack_q.push_back('{1'b1, 1'b0, DM_OP_W, 32'h04, 32'h0, k + 4});
      ack_q.push_back('{1'b0, 1'b0, DM_OP_W, 32'h10, 32'h0, k + 7});
      ack_q.push_back('{1'b1, 1'b0, DM_OP_W, 32'h04, 32'h0, k + 10});
      done_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF, k + 2});
      done_q.push_back('{1'b1, 1'b1, 32'hB1B1B1B1, k + 5});
      done_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF, k + 8});
      done_q.push_back('{1'b1, 1'b1, 32'hB1B1B1B1, k + 11});
      repeat (11) begin @(posedge clk); #1; end
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Single load, then busy must be low in the third cycle.
      single(1'b0, 1'b0, DM_OP_W, 32'h10, 32'h0, 32'hDEADBEEF);
      @(negedge clk);
      chk("busy_after_load", 32'(busy), 32'd0);
      @(posedge clk); #1;

      // Store then load on port 1.
      single(1'b1, 1'b1, DM_OP_W, 32'h20, 32'h12345678, 32'h0);
      single(1'b1, 1'b0, DM_OP_W, 32'h20, 32'h0, 32'h12345678);

      // Back-to-back loads with req0 held.
      k = cyc;
      set_port(1'b0, 1'b0, DM_OP_W, 32'h0, 32'h0);
      req0 = 1'b1;
      ack_q.push_back('{1'b0, 1'b0, DM_OP_W, 32'h0, 32'h0, k + 1});
      ack_q.push_back('{1'b0, 1'b0, DM_OP_W, 32'h4, 32'h0, k + 4});
      ack_q.push_back('{1'b0, 1'b0, DM_OP_W, 32'h8, 32'h0, k + 7});
      done_q.push_back('{1'b0, 1'b1, 32'hA0A0A0A0, k + 2});
      done_q.push_back('{1'b0, 1'b1, 32'hB1B1B1B1, k + 5});
      done_q.push_back('{1'b0, 1'b1, 32'hC2C2C2C2, k + 8});
      repeat (2) begin @(posedge clk); #1; end
      addr0 = 32'h4;
      repeat (3) begin @(posedge clk); #1; end
      addr0 = 32'h8;
      repeat (3) begin @(posedge clk); #1; end
      req0 = 1'b0;
      @(posedge clk); #1;

      // Byte op pass-through: byte store then zero-extended byte load.
      single(1'b1, 1'b1, DM_OP_SB, 32'h30, 32'h000000AB, 32'h0);
      single(1'b1, 1'b0, DM_OP_BZ, 32'h30, 32'h0, 32'h000000AB);
      single(1'b0, 1'b0, DM_OP_W, 32'h30, 32'h0, 32'h112233AB);

      // Reset during the ACCESS cycle of a load: ack still seen, no done, rdata cleared.
      k = cyc;
      set_port(1'b0, 1'b0, DM_OP_W, 32'h10, 32'h0);
      req0 = 1'b1;
      ack_q.push_back('{1'b0, 1'b0, DM_OP_W, 32'h10, 32'h0, k + 1});
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      req0 = 1'b0;
      sh0 = 32'h0;
      sh1 = 32'h0;
      @(negedge clk);
      chk("busy_after_rst", 32'(busy), 32'd0);
      chk("rdata0_after_rst", rdata0, 32'h0);
      chk("rdata1_after_rst", rdata1, 32'h0);
      @(posedge clk); #1;
      single(1'b0, 1'b0, DM_OP_W, 32'h8, 32'h0, 32'hC2C2C2C2);

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
      chk("done_queue_drained", 32'(done_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
